// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF stage PC register, IF/ID pipeline register and stall-overrun monitor
// Optional performance counters are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCWrite,
   input  logic        IF_ID_Write,
   input  logic        Branch_Taken,
   input  logic [31:0] Branch_Target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC,
   output logic [31:0] IF_ID_Instr,
   output logic [31:0] IF_ID_PCPlus4,
   output logic        IF_ID_Valid,
   output logic        Stall_Overrun,
   output logic [31:0] Stall_Count,
   output logic [31:0] Flush_Count
);

   typedef enum logic [1:0] {
      ST_RUN = 2'd0,
      ST_S1  = 2'd1,
      ST_S2  = 2'd2,
      ST_OVR = 2'd3
   } mon_state_t;

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   mon_state_t  state_q, state_d;

   logic        stall;
   logic        redirect;
   logic [31:0] pc_plus4;

   // A taken branch seen during a stall is dropped: its ID operands are stale.
   assign stall    = ~IF_ID_Write;
   assign redirect = Branch_Taken & ~stall;
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (PCWrite) begin
         pc_d = redirect ? Branch_Target : pc_plus4;
      end
      if (IF_ID_Write) begin
         if (redirect) begin
            instr_d = 32'h0000_0000;
            pc4_d   = 32'h0000_0000;
            valid_d = 1'b0;
         end else begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  state_d = stall ? ST_S1  : ST_RUN;
         ST_S1:   state_d = stall ? ST_S2  : ST_RUN;
         ST_S2:   state_d = stall ? ST_OVR : ST_RUN;
         ST_OVR:  state_d = ST_OVR;
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= 32'h0000_0000;
         instr_q <= 32'h0000_0000;
         pc4_q   <= 32'h0000_0000;
         valid_q <= 1'b0;
         state_q <= ST_RUN;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         state_q <= state_d;
      end
   end

`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (redirect && (flush_cnt_q != 32'hFFFF_FFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'h0000_0000;
         flush_cnt_q <= 32'h0000_0000;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign Stall_Count = stall_cnt_q;
   assign Flush_Count = flush_cnt_q;
`else
   assign Stall_Count = 32'h0000_0000;
   assign Flush_Count = 32'h0000_0000;
`endif

   assign imem_addr     = pc_q;
   assign PC            = pc_q;
   assign IF_ID_Instr   = instr_q;
   assign IF_ID_PCPlus4 = pc4_q;
   assign IF_ID_Valid   = valid_q;
   assign Stall_Overrun = (state_q == ST_OVR);

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage (honours IF_ID_PERF_CNT_EN)
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        PCWrite = 1'b0;
   logic        IF_ID_Write = 1'b0;
   logic        Branch_Taken = 1'b0;
   logic [31:0] Branch_Target = 32'h0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] PC;
   logic [31:0] IF_ID_Instr;
   logic [31:0] IF_ID_PCPlus4;
   logic        IF_ID_Valid;
   logic        Stall_Overrun;
   logic [31:0] Stall_Count;
   logic [31:0] Flush_Count;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_pc, m_instr, m_pc4, m_sc, m_fc;
   logic        m_valid, m_ovr;
   int          m_consec;

   if_id_stage dut (
      .clk           (clk),
      .reset         (reset),
      .PCWrite       (PCWrite),
      .IF_ID_Write   (IF_ID_Write),
      .Branch_Taken  (Branch_Taken),
      .Branch_Target (Branch_Target),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .PC            (PC),
      .IF_ID_Instr   (IF_ID_Instr),
      .IF_ID_PCPlus4 (IF_ID_PCPlus4),
      .IF_ID_Valid   (IF_ID_Valid),
      .Stall_Overrun (Stall_Overrun),
      .Stall_Count   (Stall_Count),
      .Flush_Count   (Flush_Count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h2008_0001;
      if (a == 32'h4) return 32'h2009_0002;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic pcw, input logic ifw,
                       input logic bt, input logic [31:0] tgt);
      logic        redir;
      logic [31:0] old_pc;
      @(negedge clk);
      reset         = r;
      PCWrite       = pcw;
      IF_ID_Write   = ifw;
      Branch_Taken  = bt;
      Branch_Target = tgt;
      #1;
      check("imem_addr", imem_addr, m_pc);
      redir  = bt && ifw;
      old_pc = m_pc;
      if (r) begin
         m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
         m_ovr = 0; m_consec = 0; m_sc = 0; m_fc = 0;
      end else begin
         if (pcw) m_pc = redir ? tgt : old_pc + 32'd4;
         if (ifw) begin
            if (redir) begin
               m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else begin
               m_instr = mem_word(old_pc); m_pc4 = old_pc + 32'd4; m_valid = 1;
            end
         end
         m_consec = ifw ? 0 : (m_consec < 3 ? m_consec + 1 : 3);
         if (m_consec >= 3) m_ovr = 1;
         if (!ifw && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
         if (redir && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      end
      @(posedge clk);
      #1;
      check("PC", PC, m_pc);
      check("IF_ID_Instr", IF_ID_Instr, m_instr);
      check("IF_ID_PCPlus4", IF_ID_PCPlus4, m_pc4);
      check("IF_ID_Valid", {31'b0, IF_ID_Valid}, {31'b0, m_valid});
      check("Stall_Overrun", {31'b0, Stall_Overrun}, {31'b0, m_ovr});
`ifdef IF_ID_PERF_CNT_EN
      check("Stall_Count", Stall_Count, m_sc);
      check("Flush_Count", Flush_Count, m_fc);
`else
      check("Stall_Count", Stall_Count, 32'h0);
      check("Flush_Count", Flush_Count, 32'h0);
`endif
   endtask

   initial begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_ovr = 0; m_consec = 0; m_sc = 0; m_fc = 0;

      step(1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 32'h100);
      // straight-line fetch from 0
      step(0, 1, 1, 0, 0);
      check("straight_instr0", IF_ID_Instr, 32'h2008_0001);
      step(0, 1, 1, 0, 0);
      check("straight_instr1", IF_ID_Instr, 32'h2009_0002);
      check("straight_pc", PC, 32'h8);
      // load-use stall at 0x10
      step(0, 1, 1, 1, 32'h10);
      step(0, 0, 0, 0, 0);
      check("stall_pc", PC, 32'h10);
      step(0, 1, 1, 0, 0);
      // redirect from 0x20 to 0x40
      step(0, 1, 1, 1, 32'h20);
      step(0, 1, 1, 1, 32'h40);
      check("redir_pc", PC, 32'h40);
      step(0, 1, 1, 0, 0);
      // branch during stall is ignored, then taken
      step(0, 0, 0, 1, 32'h80);
      step(0, 1, 1, 1, 32'h80);
      check("late_branch_pc", PC, 32'h80);
      // overrun after three stalls, sticky, cleared by reset
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("ovr_set", {31'b0, Stall_Overrun}, 32'h1);
      step(0, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      check("two_stall_no_ovr", {31'b0, Stall_Overrun}, 32'h0);
      // PC wrap, then reset during a stall with a pending branch
      step(0, 1, 1, 1, 32'hFFFF_FFFC);
      step(0, 1, 1, 0, 0);
      check("wrap_pc", PC, 32'h0);
      step(0, 0, 0, 1, 32'h44);
      step(1, 0, 0, 1, 32'h44);
      step(0, 1, 1, 0, 0);

      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 4) == 0),
              {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL provide port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide port: reset  input  1  synchronous active-high reset.
REQ-003 SHALL provide port: PCWrite  input  1  1 = PC may update this cycle; 0 = hold PC.
REQ-004 SHALL provide port: IF_ID_Write  input  1  1 = IF/ID register may update this cycle; 0 = hold IF/ID.
REQ-005 SHALL provide port: Branch_Taken  input  1  ID-stage branch/jump resolved taken this cycle.
REQ-006 SHALL provide port: Branch_Target  input  32  redirect address, meaningful when Branch_Taken=1.
REQ-007 SHALL provide port: imem_addr  output  32  instruction-memory address; combinationally equal to PC.
REQ-008 SHALL provide port: imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle.
REQ-009 SHALL provide port: PC  output  32  current fetch address register.
REQ-010 SHALL provide port: IF_ID_Instr  output  32  instruction latched for ID.
REQ-011 SHALL provide port: IF_ID_PCPlus4  output  32  PC+4 of the latched instruction.
REQ-012 SHALL provide port: IF_ID_Valid  output  1  1 = IF_ID_Instr is a real fetched instruction; 0 = bubble.
REQ-013 SHALL provide port: Stall_Overrun  output  1  sticky flag: stall protocol violated.
REQ-014 SHALL provide ports: Stall_Count and Flush_Count  output  32 each  performance counters (see Configuration).

Function
REQ-015 SHALL evaluate, per cycle, stall = (IF_ID_Write==0); redirect = Branch_Taken && !stall; a taken branch during a stall SHALL be ignored (its ID operands are not yet valid).
REQ-016 SHALL, when PCWrite=1 and redirect=1, load PC <= Branch_Target; when PCWrite=1 and redirect=0, load PC <= PC+4 (mod 2^32, 0xFFFFFFFC wraps to 0x00000000); when PCWrite=0, hold PC.
REQ-017 SHALL, when IF_ID_Write=1 and redirect=0, load IF_ID_Instr <= imem_rdata, IF_ID_PCPlus4 <= PC+4, IF_ID_Valid <= 1.
REQ-018 SHALL, when IF_ID_Write=1 and redirect=1, flush: IF_ID_Instr <= 0x00000000 (nop), IF_ID_PCPlus4 <= 0, IF_ID_Valid <= 0.
REQ-019 SHALL, when IF_ID_Write=0, hold IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid unchanged.
REQ-020 SHALL apply PCWrite and IF_ID_Write independently when they disagree (e.g. PCWrite=1, IF_ID_Write=0 advances PC and holds IF/ID).
REQ-021 SHALL give fetch latency of one cycle: the word at PC=A appears on IF_ID_Instr the edge after A is presented, absent stall/redirect.
REQ-022 SHALL run a stall-monitor FSM on IF_ID_Write: RUN (no stall) -> S1 on a stall cycle; S1 -> S2 on a stall cycle, S1 -> RUN otherwise; S2 -> OVR on a stall cycle, S2 -> RUN otherwise; OVR is terminal until reset.
REQ-023 SHALL assert Stall_Overrun=1 exactly while the FSM is in OVR (third consecutive stall cycle seen; legal hazards stall at most 2 consecutive cycles).
REQ-024 SHALL not let the FSM affect PC or IF/ID updates; it is observational only.

Reset
REQ-025 SHALL, on a rising edge with reset=1, set PC=0x00000000, IF_ID_Instr=0x00000000, IF_ID_PCPlus4=0, IF_ID_Valid=0, FSM=RUN, Stall_Overrun=0, Stall_Count=0, Flush_Count=0, overriding all other inputs.
REQ-026 SHALL, on reset asserted mid-stall or mid-redirect, discard the pending action; first post-reset fetch is from address 0.

Configuration
REQ-027 SHALL, with macro IF_ID_PERF_CNT_EN defined, increment Stall_Count by 1 on each non-reset cycle with IF_ID_Write=0 and Flush_Count by 1 on each redirect cycle, both saturating at 0xFFFFFFFF.
REQ-028 SHALL, with IF_ID_PERF_CNT_EN undefined, drive Stall_Count and Flush_Count constant 0 with no counter registers; all other behaviour identical.

Verification
REQ-029 Straight-line: release reset, imem returns 0x20080001 at 0, 0x20090002 at 4 -> IF_ID_Instr=0x20080001, PCPlus4=4, Valid=1 after edge 1; 0x20090002, PCPlus4=8 after edge 2; PC=8.
REQ-030 Load-use stall: PC=0x10, hold PCWrite=IF_ID_Write=0 one cycle -> PC stays 0x10, IF/ID unchanged, Stall_Count+1, Stall_Overrun=0.
REQ-031 Branch redirect: PC=0x20, Branch_Taken=1, Branch_Target=0x40, no stall -> PC=0x40, IF_ID_Instr=0, Valid=0, Flush_Count+1; next edge fetches from 0x40.
REQ-032 Branch during stall: Branch_Taken=1, Target=0x80, PCWrite=IF_ID_Write=0 -> PC and IF/ID hold, Flush_Count unchanged; after stall drops with Branch_Taken=1, PC=0x80.
REQ-033 Overrun: three consecutive stall cycles -> Stall_Overrun=1 after third edge, stays 1 after stall drops; reset clears to 0. Two consecutive stalls -> stays 0.
REQ-034 Wrap and reset: PC=0xFFFFFFFC normal step -> PC=0x00000000; assert reset mid-stall -> all outputs return to REQ-025 values.
